// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access unit placed after the ALU. It takes the ALU result as the
// effective address and rs2 as store data, runs a single load or store over a
// req/gnt/rvalid bus and returns the sign/zero-extended load data together
// with a fault flag (misaligned access, illegal funct3 or bus timeout).
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   req_valid       core access request, held until accepted
//   req_ready       high only while idle
//   req_we          1 = store, 0 = load
//   funct3[2:0]     RV32I width: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr[31:0]      byte address (ALU result)
//   wdata[31:0]     store data (rs2)
//   resp_valid      one-cycle completion pulse
//   rdata[31:0]     extended load data, 0 for stores and faults
//   fault           qualified by resp_valid
//   busy            unit is not idle
//   mem_req         bus request, held until mem_gnt
//   mem_we          bus write enable
//   mem_addr[31:0]  word-aligned bus address
//   mem_wstrb[3:0]  byte strobes, 0000 on loads
//   mem_wdata[31:0] lane-replicated store data
//   mem_gnt         bus accepted the request this cycle
//   mem_rvalid      read data / write ack valid this cycle
//   mem_rdata[31:0] word read data
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_e;

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        we_q, we_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

   logic        illegal_in;
   logic        misalign_in;
   logic        reject_in;
   logic        timeout_hit;
   logic [31:0] load_ext;
   logic [3:0]  store_strb;
   logic [31:0] store_data;

   // ------------------------------------------------------------------
   // Request screening on the incoming (not yet latched) request.
   // Stores have no unsigned variants, so 100/101 are illegal for them.
   // ------------------------------------------------------------------
   always_comb begin
      illegal_in  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                    (req_we && funct3[2]);
      misalign_in = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      reject_in   = illegal_in || misalign_in;
   end

   // WAIT has lasted TIMEOUT_CYCLES cycles once this cycle completes.
   assign timeout_hit = ((cnt_q + 8'd1) == TIMEOUT_LIM);

   // ------------------------------------------------------------------
   // Load extraction from the returned word.
   // ------------------------------------------------------------------
   always_comb begin
      logic [31:0] shifted;
      logic [15:0] half;
      logic        sgn;
      shifted = mem_rdata >> {addr_q[1:0], 3'b000};
      half    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      sgn     = ~funct3_q[2];
      case (funct3_q[1:0])
         2'b00:   load_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = {{16{sgn & half[15]}}, half};
         default: load_ext = mem_rdata;
      endcase
   end

   // ------------------------------------------------------------------
   // Store strobes and lane-replicated data.
   // ------------------------------------------------------------------
   always_comb begin
      case (funct3_q[1:0])
         2'b00: begin
            store_strb = 4'b0001 << addr_q[1:0];
            store_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            store_strb = 4'b0011 << addr_q[1:0];
            store_data = {2{wdata_q[15:0]}};
         end
         default: begin
            store_strb = 4'b1111;
            store_data = wdata_q;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = reject_in ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // rvalid in the timeout cycle still completes normally
            if (mem_rvalid || timeout_hit) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (all decoded from registered state, so the bus request
   // drops as soon as reset is asserted)
   // ------------------------------------------------------------------
   always_comb begin
      req_ready  = 1'b0;
      busy       = 1'b1;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wstrb  = '0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      rdata      = '0;
      fault      = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         S_REQ: begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
               mem_wstrb = store_strb;
               mem_wdata = store_data;
            end
         end
         S_WAIT: begin
         end
         S_RESP: begin
            resp_valid = 1'b1;
            rdata      = rdata_q;
            fault      = fault_q;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request, counter and response registers
   // ------------------------------------------------------------------
   always_comb begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = addr;
               wdata_d  = wdata;
               funct3_d = funct3;
               we_d     = req_we;
               cnt_d    = '0;
               rdata_d  = '0;
               fault_d  = reject_in;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               cnt_d = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (mem_rvalid) begin
               rdata_d = we_q ? '0 : load_ext;
               fault_d = 1'b0;
            end else if (timeout_hit) begin
               rdata_d = '0;
               fault_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        fault;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [32:0] exp_q[$];
   logic [32:0] mon_e;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .resp_valid (resp_valid),
      .rdata      (rdata),
      .fault      (fault),
      .busy       (busy),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every response pulse pops one expectation.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'(resp_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rdata", rdata, mon_e[31:0]);
            check("fault", 32'(fault), 32'(mon_e[32]));
         end
      end
   end

   // Reference strobes/data for stores, written out per offset.
   function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] o);
      logic [3:0] s;
      if (f3[1:0] == 2'b10) s = 4'b1111;
      else if (f3[1:0] == 2'b01) s = (o[1]) ? 4'b1100 : 4'b0011;
      else begin
         case (o)
            2'd0: s = 4'b0001;
            2'd1: s = 4'b0010;
            2'd2: s = 4'b0100;
            default: s = 4'b1000;
         endcase
      end
      return s;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
      return d;
   endfunction

   // Issue one access and act as the bus. Called #1 after a rising edge with
   // the unit idle. gnt_dly: REQ cycles before the grant; rv_dly: WAIT cycles
   // before rvalid (-1 = never). exp_lat: cycles from accept to resp_valid.
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] bus_rd, input logic [31:0] exp_rd,
                         input logic exp_flt, input logic exp_bus, input int exp_lat);
      int cyc;
      int n_req;
      int n_wait;
      bit granted;
      bit saw_req;
      bit done;
      exp_q.push_back({exp_flt, exp_rd});
      check("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      addr      = 32'hFFFF_FFFF;
      wdata     = 32'h5555_5555;
      cyc = 1; n_req = 0; n_wait = 0; granted = 0; saw_req = 0; done = 0;
      while (!done && cyc < 60) begin
         if (resp_valid) begin
            done = 1;
            check("latency", 32'(cyc), 32'(exp_lat));
            if (exp_bus && rv_dly < 0) check("wait_len", 32'(n_wait), 32'(TO));
            if (!exp_bus) check("no_bus", 32'(saw_req), 32'd0);
         end else begin
            if (mem_req) begin
               saw_req = 1;
               n_req++;
               check("mem_addr", mem_addr, {a[31:2], 2'b00});
               check("mem_we", 32'(mem_we), 32'(we));
               check("mem_wstrb", 32'(mem_wstrb), we ? 32'(ref_strb(f3, a[1:0])) : 32'd0);
               if (we) check("mem_wdata", mem_wdata, ref_wdata(f3, wd));
               if (n_req > gnt_dly) begin
                  mem_gnt = 1'b1;
               end else begin
                  // stray rvalid while still requesting must be ignored
                  mem_rvalid = 1'b1;
                  mem_rdata  = 32'hBADB_AD00;
               end
            end else if (granted) begin
               n_wait++;
               if (rv_dly >= 0 && n_wait > rv_dly) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = bus_rd;
               end
            end
            @(posedge clk); #1;
            if (mem_gnt) granted = 1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0BAD_0BAD;
            cyc++;
         end
      end
      if (!done) check("resp_timeout", 32'd0, 32'd1);
      if (!exp_bus && exp_lat == 1) check("resp_len", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("back_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      funct3     = 3'b000;
      addr       = '0;
      wdata      = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_wstrb", 32'(mem_wstrb), 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // loads: word, then byte/half extraction
      run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 3);
      run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_FF00, 32'hFFFF_FF80, 1'b0, 1'b1, 3);
      run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF_FF00, 32'h0000_0080, 1'b0, 1'b1, 3);
      run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80FF_FF00, 32'h0000_80FF, 1'b0, 1'b1, 3);
      run_op(1'b0, 3'b001, 32'h100, 32'h0, 0, 0, 32'h80FF_FF00, 32'hFFFF_FF00, 1'b0, 1'b1, 3);
      run_op(1'b0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h80FF_FF00, 32'hFFFF_FFFF, 1'b0, 1'b1, 3);
      run_op(1'b0, 3'b100, 32'h100, 32'h0, 1, 1, 32'h1234_567F, 32'h0000_007F, 1'b0, 1'b1, 5);

      // stores: rdata must be 0 regardless of bus data
      run_op(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 3);
      run_op(1'b1, 3'b000, 32'h201, 32'h0000_005A, 0, 0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 3);
      run_op(1'b1, 3'b000, 32'h203, 32'hCAFE_F00D, 0, 0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 3);
      run_op(1'b1, 3'b010, 32'h204, 32'hA5A5_1234, 0, 2, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 5);

      // rejected requests: misaligned / illegal, no bus traffic
      run_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
      run_op(1'b1, 3'b001, 32'h001, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
      run_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
      run_op(1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
      run_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1);

      // delayed grant then bus timeout; then rvalid on the last WAIT cycle wins
      run_op(1'b0, 3'b010, 32'h400, 32'h0, 5, -1, 32'h0, 32'h0, 1'b1, 1'b1, 11);
      run_op(1'b0, 3'b010, 32'h404, 32'h0, 0, TO - 1, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1'b1, 2 + TO);

      // stray bus handshakes while idle
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check("stray_busy", 32'(busy), 32'd0);
      check("stray_ready", 32'(req_ready), 32'd1);

      // reset while requesting
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("pre_rst_req", 32'(mem_req), 32'd1);
      rst = 1'b0; #1;
      check("rstreq_mem_req", 32'(mem_req), 32'd0);
      check("rstreq_busy", 32'(busy), 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // reset while waiting, then a late rvalid
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      check("wait_busy", 32'(busy), 32'd1);
      rst = 1'b0; #1;
      check("rstwait_mem_req", 32'(mem_req), 32'd0);
      check("rstwait_busy", 32'(busy), 32'd0);
      check("rstwait_resp", 32'(resp_valid), 32'd0);
      check("rstwait_ready", 32'(req_ready), 32'd1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      check("late_rvalid_busy", 32'(busy), 32'd0);
      check("late_rvalid_resp", 32'(resp_valid), 32'd0);

      run_op(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 1'b1, 3);

      @(posedge clk); #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
